// File: rtl/axi_fifo_arbiter_pkg.sv
// rtl/axi_fifo_arbiter_pkg.sv - shared defaults and FSM encoding for the multicast replicator
package axi_fifo_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 202;
  localparam int DEF_NUM_QUEUES = 5;
  localparam int DEF_QID_WIDTH  = 3;

  // IDLE: nothing held; BUSY: word in dout register, remaining copies in held mask
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/axi_fifo_arbiter_pick.sv
// rtl/axi_fifo_arbiter_pick.sv - destination picker, rotating start when AXI_FIFO_ARBITER_ROUND_ROBIN_EN is defined
module axi_fifo_arbiter_pick
  import axi_fifo_arbiter_pkg::*;
#(
  parameter int NUM_QUEUES = DEF_NUM_QUEUES,
  parameter int QID_WIDTH  = DEF_QID_WIDTH
) (
  input  logic [NUM_QUEUES-1:0] i_mask,
`ifdef AXI_FIFO_ARBITER_ROUND_ROBIN_EN
  input  logic [QID_WIDTH-1:0]  i_start,
`endif
  output logic                  o_found,
  output logic [QID_WIDTH-1:0]  o_index,
  output logic [NUM_QUEUES-1:0] o_mask_rest,
  output logic                  o_last
);

  // Select one set bit, then report the mask without it and whether it was the only one
  always_comb begin
    int w_idx;
    o_found     = 1'b0;
    o_index     = '0;
    w_idx       = 0;
`ifdef AXI_FIFO_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < NUM_QUEUES; k++) begin
      w_idx = int'(i_start) + k;
      if (w_idx >= NUM_QUEUES) w_idx = w_idx - NUM_QUEUES;
      if (!o_found && i_mask[w_idx]) begin
        o_found = 1'b1;
        o_index = QID_WIDTH'(w_idx);
      end
    end
`else
    // Scan downward so the lowest set bit wins
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      if (i_mask[k]) begin
        o_found = 1'b1;
        o_index = QID_WIDTH'(k);
      end
    end
`endif
    o_mask_rest = i_mask;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      if (o_found && (o_index == QID_WIDTH'(k))) o_mask_rest[k] = 1'b0;
    end
    o_last = o_found && (o_mask_rest == '0);
  end

endmodule

// File: rtl/axi_fifo_arbiter.sv
// rtl/axi_fifo_arbiter.sv - multicast word replicator; AXI_FIFO_ARBITER_ROUND_ROBIN_EN selects rotating queue order
module axi_fifo_arbiter
  import axi_fifo_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_QUEUES = DEF_NUM_QUEUES,
  parameter int QID_WIDTH  = DEF_QID_WIDTH
) (
  input  logic                  memclk,
  input  logic                  reset,
  input  logic [NUM_QUEUES-1:0] oq,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  next_pkg_en,
  output logic [QID_WIDTH-1:0]  queue_id,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  state_t                r_state;
  state_t                w_state_next;
  logic [NUM_QUEUES-1:0] r_mask;
  logic [NUM_QUEUES-1:0] w_mask_next;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] w_dout_next;
  logic [QID_WIDTH-1:0]  r_qid;
  logic [QID_WIDTH-1:0]  w_qid_next;
  logic                  r_dout_valid;
  logic                  w_dout_valid_next;
  logic                  w_ack;

  logic [NUM_QUEUES-1:0] w_pick_mask;
  logic                  w_found;
  logic [QID_WIDTH-1:0]  w_index;
  logic [NUM_QUEUES-1:0] w_rest;
  logic                  w_last;

  // In IDLE the live request is examined; in BUSY only the remaining held copies
  assign w_pick_mask = (r_state == ST_IDLE) ? oq : r_mask;

`ifdef AXI_FIFO_ARBITER_ROUND_ROBIN_EN
  logic [QID_WIDTH-1:0] r_last_q;
  logic [QID_WIDTH-1:0] w_start;

  assign w_start = (r_last_q == QID_WIDTH'(NUM_QUEUES - 1)) ? '0 : r_last_q + 1'b1;

  // Remember the last issued queue so the next search begins just after it
  always_ff @(posedge memclk) begin
    if (reset) begin
      r_last_q <= QID_WIDTH'(NUM_QUEUES - 1);
    end else if (w_dout_valid_next) begin
      r_last_q <= w_index;
    end
  end
`endif

  axi_fifo_arbiter_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .QID_WIDTH  (QID_WIDTH)
  ) u_pick (
    .i_mask      (w_pick_mask),
`ifdef AXI_FIFO_ARBITER_ROUND_ROBIN_EN
    .i_start     (w_start),
`endif
    .o_found     (w_found),
    .o_index     (w_index),
    .o_mask_rest (w_rest),
    .o_last      (w_last)
  );

  // Next-state and issue decisions; the dout register doubles as the held word while BUSY
  always_comb begin
    w_state_next      = r_state;
    w_mask_next       = r_mask;
    w_dout_next       = r_dout;
    w_qid_next        = r_qid;
    w_dout_valid_next = 1'b0;
    w_ack             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (din_valid) begin
          if (!w_found) begin
            w_ack = 1'b1;
          end else begin
            w_dout_next       = din;
            w_qid_next        = w_index;
            w_dout_valid_next = 1'b1;
            if (w_last) begin
              w_ack = 1'b1;
            end else begin
              w_mask_next  = w_rest;
              w_state_next = ST_BUSY;
            end
          end
        end
      end
      ST_BUSY: begin
        if (w_found) begin
          w_qid_next        = w_index;
          w_dout_valid_next = 1'b1;
          w_mask_next       = w_rest;
          if (w_last) begin
            w_ack        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register and registered output stage
  always_ff @(posedge memclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_dout       <= '0;
      r_qid        <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_mask       <= w_mask_next;
      r_dout       <= w_dout_next;
      r_qid        <= w_qid_next;
      r_dout_valid <= w_dout_valid_next;
    end
  end

  assign next_pkg_en = w_ack & ~reset;
  assign queue_id    = r_qid;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;

endmodule

// File: tb/tb_axi_fifo_arbiter.sv
// tb/tb_axi_fifo_arbiter.sv - directed vector bench for axi_fifo_arbiter (AXI_FIFO_ARBITER_ROUND_ROBIN_EN aware)
module tb_axi_fifo_arbiter;
  import axi_fifo_arbiter_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int NQ = DEF_NUM_QUEUES;
  localparam int QW = DEF_QID_WIDTH;

`ifdef AXI_FIFO_ARBITER_ROUND_ROBIN_EN
  localparam logic [2:0] Q_A = 3'd3;
  localparam logic [2:0] Q_B = 3'd4;
  localparam logic [2:0] Q_C = 3'd0;
  localparam logic [2:0] Q_D = 3'd1;
`else
  localparam logic [2:0] Q_A = 3'd0;
  localparam logic [2:0] Q_B = 3'd3;
  localparam logic [2:0] Q_C = 3'd4;
  localparam logic [2:0] Q_D = 3'd0;
`endif

  logic          memclk;
  logic          reset;
  logic [NQ-1:0] oq;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          next_pkg_en;
  logic [QW-1:0] queue_id;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int n_checks;
  int n_err;

  axi_fifo_arbiter dut (
    .memclk      (memclk),
    .reset       (reset),
    .oq          (oq),
    .din_valid   (din_valid),
    .din         (din),
    .next_pkg_en (next_pkg_en),
    .queue_id    (queue_id),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  initial memclk = 1'b0;
  always #5 memclk = ~memclk;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [4:0] m;
    int         d;
    logic       ack;
    logic       ov;
    logic [2:0] q;
    int         dq;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input int idx, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h", name, idx, got, exp);
    end
  endtask

  // Source that advances its word on every ack; checks a gap-free copy stream
  task automatic run_stream(input logic [4:0] m, input int first, input int n, input int k, input int ord [5]);
    int   acks;
    int   total;
    logic got_ack;
    acks      = 0;
    total     = n * k;
    oq        = m;
    din       = DW'(first);
    din_valid = 1'b1;
    for (int c = 0; c <= total + 1; c++) begin
      @(negedge memclk);
      got_ack = next_pkg_en;
      chk("stream_ack", c, DW'(got_ack), DW'((c < total) && ((c % k) == k - 1)));
      if (c >= 1 && c <= total) begin
        chk("stream_valid", c, DW'(dout_valid), DW'(1));
        chk("stream_qid", c, DW'(queue_id), DW'(ord[(c - 1) % k]));
        chk("stream_dout", c, dout, DW'(first + (c - 1) / k));
      end else if (c == total + 1) begin
        chk("stream_end_valid", c, DW'(dout_valid), DW'(0));
      end
      @(posedge memclk);
      #1;
      if (got_ack) begin
        acks++;
        din = DW'(first + acks);
        if (acks == n) din_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int ord_a [5];
    n_checks = 0;
    n_err    = 0;

    //             rst   dv    mask      din  ack   ov    qid   dout
    tbl[0]  = '{1'b1, 1'b1, 5'b01011, 7,   1'b0, 1'b0, 3'd0, 0};
    tbl[1]  = '{1'b0, 1'b1, 5'b01011, 1,   1'b0, 1'b0, 3'd0, 0};
    tbl[2]  = '{1'b0, 1'b1, 5'b01011, 9,   1'b0, 1'b1, 3'd0, 1};
    tbl[3]  = '{1'b0, 1'b1, 5'b01011, 9,   1'b1, 1'b1, 3'd1, 1};
    tbl[4]  = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b1, 3'd3, 1};
    tbl[5]  = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b0, 3'd3, 1};
    tbl[6]  = '{1'b0, 1'b1, 5'b00100, 20,  1'b1, 1'b0, 3'd3, 1};
    tbl[7]  = '{1'b0, 1'b1, 5'b00100, 21,  1'b1, 1'b1, 3'd2, 20};
    tbl[8]  = '{1'b0, 1'b1, 5'b00100, 22,  1'b1, 1'b1, 3'd2, 21};
    tbl[9]  = '{1'b0, 1'b1, 5'b00000, 30,  1'b1, 1'b1, 3'd2, 22};
    tbl[10] = '{1'b0, 1'b1, 5'b00000, 31,  1'b1, 1'b0, 3'd2, 22};
    tbl[11] = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b0, 3'd2, 22};
    tbl[12] = '{1'b0, 1'b1, 5'b11001, 101, 1'b0, 1'b0, 3'd2, 22};
    tbl[13] = '{1'b0, 1'b1, 5'b11001, 101, 1'b0, 1'b1, Q_A,  101};
    tbl[14] = '{1'b0, 1'b1, 5'b11001, 101, 1'b1, 1'b1, Q_B,  101};
    tbl[15] = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b1, Q_C,  101};
    tbl[16] = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b0, Q_C,  101};
    tbl[17] = '{1'b0, 1'b1, 5'b11111, 55,  1'b0, 1'b0, Q_C,  101};
    tbl[18] = '{1'b1, 1'b1, 5'b11111, 55,  1'b0, 1'b1, Q_D,  55};
    tbl[19] = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b0, 3'd0, 0};
    tbl[20] = '{1'b0, 1'b0, 5'b00000, 0,   1'b0, 1'b0, 3'd0, 0};

    reset     = 1'b1;
    din_valid = 1'b0;
    oq        = '0;
    din       = '0;
    repeat (3) @(posedge memclk);
    #1;

    for (int i = 0; i < 21; i++) begin
      reset     = tbl[i].rst;
      din_valid = tbl[i].dv;
      oq        = tbl[i].m;
      din       = DW'(tbl[i].d);
      @(negedge memclk);
      chk("vec_ack", i, DW'(next_pkg_en), DW'(tbl[i].ack));
      chk("vec_valid", i, DW'(dout_valid), DW'(tbl[i].ov));
      chk("vec_qid", i, DW'(queue_id), DW'(tbl[i].q));
      chk("vec_dout", i, dout, DW'(tbl[i].dq));
      @(posedge memclk);
      #1;
    end

    ord_a = '{0, 1, 3, 0, 0};
    run_stream(5'b01011, 2, 30, 3, ord_a);

`ifdef AXI_FIFO_ARBITER_ROUND_ROBIN_EN
    ord_a = '{4, 0, 3, 0, 0};
`else
    ord_a = '{0, 3, 4, 0, 0};
`endif
    run_stream(5'b11001, 101, 3, 3, ord_a);

    reset = 1'b1;
    repeat (2) @(posedge memclk);
    #1;
    reset = 1'b0;
    ord_a = '{0, 1, 2, 3, 4};
    run_stream(5'b11111, 200, 2, 5, ord_a);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
